// File: rtl/pci_tx_pkg.sv
// Shared definitions for the PCIe transmit path: default geometry, channel
// index width helper and flag bit ordering shared with the lane distributor.
package pci_tx_pkg;

  localparam int DEFAULT_DATA_W = 6;
  localparam int DEFAULT_ADDR_W = 2;
  localparam int DEFAULT_N_CH   = 4;

  // Bit positions inside a per-channel flag vector
  localparam int FLAG_FULL  = 0;
  localparam int FLAG_EMPTY = 1;
  localparam int FLAG_AF    = 2;
  localparam int FLAG_AE    = 3;
  localparam int FLAG_ERR   = 4;
  localparam int N_FLAGS    = 5;

  function automatic int ch_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/pci_vc_fifo_chan.sv
// One virtual-channel FIFO: storage, pointers, occupancy, flags and the
// sticky overflow/underflow error.
module pci_vc_fifo_chan
  import pci_tx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               wr_sel,
  input  logic               rd_sel,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [ADDR_W:0]    umbral_af,
  input  logic [ADDR_W:0]    umbral_ae,
  output logic               rd_ok,
  output logic [DATA_W-1:0]  rd_data,
  output logic [N_FLAGS-1:0] flags
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   cnt_r;
  logic              err_r;
  logic              wr_ok;
  logic              is_full;
  logic              is_empty;
  logic [ADDR_W:0]   af_sat;
  logic [ADDR_W:0]   af_thr;

  // Accept decisions and flags; a full channel still takes a write when it is read in the same cycle
  always_comb begin
    is_full  = (cnt_r == DEPTH_V);
    is_empty = (cnt_r == '0);
    rd_ok    = rd_sel && !is_empty;
    wr_ok    = wr_sel && (!is_full || rd_ok);
    if (umbral_af > DEPTH_V) begin
      af_sat = DEPTH_V;
    end else begin
      af_sat = umbral_af;
    end
    af_thr = DEPTH_V - af_sat;
    flags = '0;
    flags[FLAG_FULL]  = is_full;
    flags[FLAG_EMPTY] = is_empty;
    flags[FLAG_AF]    = (cnt_r >= af_thr) && !is_full;
    flags[FLAG_AE]    = !is_empty && (cnt_r <= umbral_ae);
    flags[FLAG_ERR]   = err_r;
  end

  assign rd_data = mem[rd_ptr_r];

  // Pointer, occupancy and sticky error state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else if (!init) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
      if ((wr_sel && !wr_ok) || (rd_sel && is_empty)) begin
        err_r <= 1'b1;
      end
    end
  end

  // Storage needs no reset; only accepted writes outside a soft clear land
  always_ff @(posedge clk) begin
    if (init && wr_ok) begin
      mem[wr_ptr_r] <= data_in;
    end
  end

endmodule

// File: rtl/pci_vc_fifo_bank.sv
// Bank of N_CH virtual-channel FIFOs behind one write port and one read
// port; read data from the addressed channel is registered into data_out.
module pci_vc_fifo_bank
  import pci_tx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int N_CH   = DEFAULT_N_CH,
  localparam int CH_W  = ch_width(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W:0]   umbral_af,
  input  logic [ADDR_W:0]   umbral_ae,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [N_CH-1:0]   full,
  output logic [N_CH-1:0]   empty,
  output logic [N_CH-1:0]   almost_full,
  output logic [N_CH-1:0]   almost_empty,
  output logic [N_CH-1:0]   error
);

  logic [N_CH-1:0]    ch_rd_ok;
  logic [DATA_W-1:0]  ch_rd_data [N_CH];
  logic [N_FLAGS-1:0] ch_flags   [N_CH];
  logic               rd_hit;
  logic [DATA_W-1:0]  rd_word;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pci_vc_fifo_chan #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .init      (init),
      .wr_sel    (wr_en && (wr_ch == CH_W'(i))),
      .rd_sel    (rd_en && (rd_ch == CH_W'(i))),
      .data_in   (data_in),
      .umbral_af (umbral_af),
      .umbral_ae (umbral_ae),
      .rd_ok     (ch_rd_ok[i]),
      .rd_data   (ch_rd_data[i]),
      .flags     (ch_flags[i])
    );

    assign full[i]         = ch_flags[i][FLAG_FULL];
    assign empty[i]        = ch_flags[i][FLAG_EMPTY];
    assign almost_full[i]  = ch_flags[i][FLAG_AF];
    assign almost_empty[i] = ch_flags[i][FLAG_AE];
    assign error[i]        = ch_flags[i][FLAG_ERR];
  end

  // Select the addressed channel's head word and accept status
  always_comb begin
    rd_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_hit  = ch_rd_ok[i];
        rd_word = ch_rd_data[i];
      end else begin
        rd_hit  = rd_hit;
        rd_word = rd_word;
      end
    end
  end

  // Output register: data_out is forced to zero whenever no read was accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (!init) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_hit;
      data_out  <= rd_hit ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_pci_vc_fifo_bank.sv
// Directed self-checking bench for pci_vc_fifo_bank with hand-computed
// expectations (DATA_W=6, DEPTH=4, N_CH=4).
module tb_pci_vc_fifo_bank;

  logic       clk;
  logic       reset;
  logic       init;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [5:0] data_in;
  logic       rd_en;
  logic [1:0] rd_ch;
  logic [2:0] umbral_af;
  logic [2:0] umbral_ae;
  logic [5:0] data_out;
  logic       valid_out;
  logic [3:0] full;
  logic [3:0] empty;
  logic [3:0] almost_full;
  logic [3:0] almost_empty;
  logic [3:0] error;

  int tests_run;
  int tests_failed;

  pci_vc_fifo_bank dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .rd_ch        (rd_ch),
    .umbral_af    (umbral_af),
    .umbral_ae    (umbral_ae),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [1:0] wc, input logic [5:0] d,
                         input logic re, input logic [1:0] rc);
    wr_en   = we;
    wr_ch   = wc;
    data_in = d;
    rd_en   = re;
    rd_ch   = rc;
  endtask

  task automatic check_read(input string tag, input logic [5:0] exp);
    check_eq({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check_eq({tag, "_data"}, {26'd0, data_out}, {26'd0, exp});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    init      = 1'b1;
    umbral_af = 3'd0;
    umbral_ae = 3'd0;
    set_req(1'b0, 2'd0, 6'd0, 1'b0, 2'd0);
    #12;
    check_eq("rst_data", {26'd0, data_out}, 32'd0);
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_full", {28'd0, full}, 32'h0);
    check_eq("rst_empty", {28'd0, empty}, 32'hF);
    check_eq("rst_af", {28'd0, almost_full}, 32'h0);
    check_eq("rst_ae", {28'd0, almost_empty}, 32'h0);
    check_eq("rst_err", {28'd0, error}, 32'h0);
    reset = 1'b0;
    tick();

    // Fill ch0 with 1..4 then drain in order
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b1, 2'd0, 6'(i), 1'b0, 2'd0);
      tick();
    end
    set_req(1'b0, 2'd0, 6'd0, 1'b0, 2'd0);
    check_eq("fill0_full", {28'd0, full}, 32'h1);
    check_eq("fill0_empty", {28'd0, empty}, 32'hE);
    check_eq("fill0_af", {28'd0, almost_full}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd0);
      tick();
      check_read("rd0", 6'(i));
    end
    set_req(1'b0, 2'd0, 6'd0, 1'b0, 2'd0);
    tick();
    check_eq("idle_valid", {31'd0, valid_out}, 32'd0);
    check_eq("idle_data", {26'd0, data_out}, 32'd0);
    check_eq("drain0_empty", {28'd0, empty}, 32'hF);
    check_eq("drain0_err", {28'd0, error}, 32'h0);

    // Thresholds on ch2
    umbral_af = 3'd1;
    umbral_ae = 3'd1;
    set_req(1'b1, 2'd2, 6'h11, 1'b0, 2'd0); tick();
    check_eq("th_ae_c1", {28'd0, almost_empty}, 32'h4);
    set_req(1'b1, 2'd2, 6'h12, 1'b0, 2'd0); tick();
    check_eq("th_af_c2", {28'd0, almost_full}, 32'h0);
    check_eq("th_ae_c2", {28'd0, almost_empty}, 32'h0);
    set_req(1'b1, 2'd2, 6'h13, 1'b0, 2'd0); tick();
    check_eq("th_af_c3", {28'd0, almost_full}, 32'h4);
    set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd2); tick();
    check_read("th_rd1", 6'h11);
    set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd2); tick();
    check_read("th_rd2", 6'h12);
    check_eq("th_ae_c1b", {28'd0, almost_empty}, 32'h4);
    check_eq("th_af_c1b", {28'd0, almost_full}, 32'h0);
    set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd2); tick();
    check_read("th_rd3", 6'h13);
    check_eq("th_ae_c0", {28'd0, almost_empty}, 32'h0);
    umbral_af = 3'd0;
    umbral_ae = 3'd0;

    // ch1: same-cycle read+write when full, then overflow drop
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b1, 2'd1, 6'(8'h20 + i), 1'b0, 2'd0);
      tick();
    end
    set_req(1'b1, 2'd1, 6'h25, 1'b1, 2'd1); tick();
    check_read("rw_full", 6'h21);
    check_eq("rw_full_flag", {28'd0, full}, 32'h2);
    check_eq("rw_full_err", {28'd0, error}, 32'h0);
    set_req(1'b1, 2'd1, 6'h26, 1'b0, 2'd0); tick();
    check_eq("ovf_err", {28'd0, error}, 32'h2);
    check_eq("ovf_full", {28'd0, full}, 32'h2);
    for (int i = 2; i <= 5; i++) begin
      set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd1);
      tick();
      check_read("ovf_drain", 6'(8'h20 + i));
    end
    check_eq("ovf_empty", {28'd0, empty}, 32'hF);

    // Underflow on ch3 with a same-cycle write: no bypass
    set_req(1'b1, 2'd3, 6'h31, 1'b1, 2'd3); tick();
    check_eq("udf_valid", {31'd0, valid_out}, 32'd0);
    check_eq("udf_data", {26'd0, data_out}, 32'd0);
    check_eq("udf_err", {28'd0, error}, 32'hA);
    check_eq("udf_empty", {28'd0, empty}, 32'h7);
    set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd3); tick();
    check_read("udf_late", 6'h31);
    set_req(1'b1, 2'd0, 6'h3F, 1'b0, 2'd0);
    init = 1'b0;
    tick();
    init = 1'b1;
    set_req(1'b0, 2'd0, 6'd0, 1'b0, 2'd0);
    check_eq("init_err", {28'd0, error}, 32'h0);
    check_eq("init_empty", {28'd0, empty}, 32'hF);
    check_eq("init_valid", {31'd0, valid_out}, 32'd0);

    // Almost-full threshold above DEPTH saturates: every non-full channel flags
    umbral_af = 3'd7;
    #1;
    check_eq("af_sat", {28'd0, almost_full}, 32'hF);
    umbral_af = 3'd0;

    // Interleaved ch0/ch1 traffic across pointer wrap
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'd1, 6'(8'h20 + i), 1'b0, 2'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'd0, 6'(8'h10 + i), 1'b1, 2'd1);
      tick();
      check_read("il_a", 6'(8'h20 + i));
    end
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'd1, 6'(8'h24 + i), 1'b1, 2'd0);
      tick();
      check_read("il_b", 6'(8'h10 + i));
    end
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'd0, 6'(8'h14 + i), 1'b1, 2'd1);
      tick();
      check_read("il_c", 6'(8'h24 + i));
    end
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd0);
      tick();
      check_read("il_d", 6'(8'h14 + i));
    end
    check_eq("il_err", {28'd0, error}, 32'h0);
    check_eq("il_empty", {28'd0, empty}, 32'hF);

    // Asynchronous reset mid-read with ch0 holding two words
    set_req(1'b1, 2'd0, 6'h05, 1'b0, 2'd0); tick();
    set_req(1'b1, 2'd0, 6'h06, 1'b0, 2'd0); tick();
    set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd0); tick();
    check_read("ar_pre", 6'h05);
    #1;
    reset = 1'b1;
    #1;
    check_eq("ar_valid", {31'd0, valid_out}, 32'd0);
    check_eq("ar_data", {26'd0, data_out}, 32'd0);
    check_eq("ar_empty", {28'd0, empty}, 32'hF);
    check_eq("ar_full", {28'd0, full}, 32'h0);
    set_req(1'b0, 2'd0, 6'd0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    set_req(1'b0, 2'd0, 6'd0, 1'b1, 2'd0); tick();
    check_eq("ar_discard", {31'd0, valid_out}, 32'd0);
    check_eq("ar_discard_err", {28'd0, error}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
